// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and the
// owner codes that drive the memory-side address/data mux select.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_D  = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fetch starvation guard: counts data wins while fetch waits and forces a fetch win at STARVE_MAX.
// Only compiled when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic force_if
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt;

    // Saturating: once at the limit, it stays there until fetch is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (if_gnt) begin
            cnt <= '0;
        end else if (d_gnt && if_req && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_if = (cnt == CNT_MAX);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port arbiter between instruction fetch and data access.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; arbitrate and grant combinationally
// REQ     | mem_req high with latched command, waiting for mem_gnt
// WAIT    | command accepted, waiting for mem_rvalid
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,

    output logic            sel,
    output logic            busy
);

    arb_state_e state;
    arb_state_e state_nxt;
    logic       pick_if;
    logic       pick_d;
    logic       force_if;
    logic       resp_done;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_gnt   (pick_if),
        .d_gnt    (pick_d),
        .force_if (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // force_if only matters when both sides are requesting.
    always_comb begin
        pick_if   = 1'b0;
        pick_d    = 1'b0;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (if_req && (!d_req || force_if)) begin
                    pick_if = 1'b1;
                end else if (d_req) begin
                    pick_d = 1'b1;
                end
                if (pick_if || pick_d) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign if_gnt    = pick_if;
    assign d_gnt     = pick_d;
    assign busy      = (state != ST_IDLE);
    assign resp_done = (state == ST_WAIT) && mem_rvalid;

    // Command latch; a fetch leaves mem_wdata as it was.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel       <= SEL_IF;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (pick_d) begin
            sel       <= SEL_D;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
        end else if (pick_if) begin
            sel       <= SEL_IF;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_be    <= '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req <= 1'b0;
        end else begin
            mem_req <= (state_nxt == ST_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= resp_done && (sel == SEL_IF);
            d_rvalid  <= resp_done && (sel == SEL_D);
            if (resp_done && (sel == SEL_IF)) begin
                if_rdata <= mem_rdata;
            end
            if (resp_done && (sel == SEL_D)) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model (honours ARB_STARVE_GUARD_EN).
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int BW         = DW / 8;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          sel;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW (AW), .DW (DW), .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .if_req (if_req), .if_addr (if_addr), .if_gnt (if_gnt),
        .if_rvalid (if_rvalid), .if_rdata (if_rdata),
        .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata), .d_be (d_be),
        .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_be (mem_be), .mem_gnt (mem_gnt), .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata),
        .sel (sel), .busy (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction seen as busy/accepted flags.
    bit            m_busy, m_acc, m_owner_d, m_we, m_wd_valid, m_rv_if, m_rv_d;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rd_if, m_rd_d;
    logic [BW-1:0] m_be;
    int            m_cnt;
    bit            e_if_gnt, e_d_gnt;

    logic          o_if_gnt, o_d_gnt, o_mem_req, o_if_rvalid, o_d_rvalid, o_busy, o_sel, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_if_rdata, o_d_rdata, o_mem_wdata;

    bit            if_pend, d_pend;

    function automatic void model_reset();
        m_busy = 0; m_acc = 0; m_owner_d = 0; m_we = 0; m_wd_valid = 1;
        m_rv_if = 0; m_rv_d = 0; m_addr = '0; m_wdata = '0; m_be = '0;
        m_rd_if = '0; m_rd_d = '0; m_cnt = 0;
    endfunction

    function automatic bit fetch_forced();
`ifdef ARB_STARVE_GUARD_EN
        return m_cnt == STARVE_MAX;
`else
        return 1'b0;
`endif
    endfunction

    // Inputs are set by the caller just after a rising edge; this predicts,
    // samples at the falling edge, checks, then advances the model.
    task automatic step();
        bit win_if;
        win_if   = if_req && (!d_req || fetch_forced());
        e_if_gnt = !m_busy && win_if;
        e_d_gnt  = !m_busy && d_req && !win_if;
        @(negedge clk);
        o_if_gnt = if_gnt; o_d_gnt = d_gnt; o_mem_req = mem_req; o_busy = busy; o_sel = sel;
        o_if_rvalid = if_rvalid; o_d_rvalid = d_rvalid; o_if_rdata = if_rdata; o_d_rdata = d_rdata;
        o_mem_addr = mem_addr; o_mem_we = mem_we; o_mem_wdata = mem_wdata;
        check("if_gnt", if_gnt, e_if_gnt);
        check("d_gnt", d_gnt, e_d_gnt);
        check("mem_req", mem_req, m_busy && !m_acc);
        check("busy", busy, m_busy);
        check("sel", sel, m_owner_d);
        check("mem_addr", mem_addr, m_addr);
        check("mem_we", mem_we, m_we);
        check("mem_be", mem_be, m_be);
        if (m_wd_valid) check("mem_wdata", mem_wdata, m_wdata);
        check("if_rvalid", if_rvalid, m_rv_if);
        check("d_rvalid", d_rvalid, m_rv_d);
        check("if_rdata", if_rdata, m_rd_if);
        check("d_rdata", d_rdata, m_rd_d);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_rv_if = 0;
            m_rv_d  = 0;
            if (m_busy && m_acc) begin
                if (mem_rvalid) begin
                    if (m_owner_d) begin m_rv_d = 1; m_rd_d = mem_rdata; end
                    else begin m_rv_if = 1; m_rd_if = mem_rdata; end
                    m_busy = 0;
                end
            end else if (m_busy) begin
                if (mem_gnt) m_acc = 1;
            end else if (e_if_gnt) begin
                m_busy = 1; m_acc = 0; m_owner_d = 0;
                m_we = 0; m_addr = if_addr; m_be = '1; m_wd_valid = 0;
                m_cnt = 0;
            end else if (e_d_gnt) begin
                m_busy = 1; m_acc = 0; m_owner_d = 1;
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be; m_wd_valid = 1;
                if (if_req && m_cnt < STARVE_MAX) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic drain(input int n);
        if_req = 0; d_req = 0; mem_gnt = 1; mem_rvalid = 1;
        repeat (n) step();
        mem_gnt = 0; mem_rvalid = 0;
    endtask

    initial begin
        int n_req, n_gnt, n_rv, n_grants;
        bit order[15];

        rst_n = 0;
        quiet_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;

        step();
        check("rst_busy", o_busy, 0);
        check("rst_mem_req", o_mem_req, 0);
        check("rst_sel", o_sel, 0);
        check("rst_if_rdata", o_if_rdata, 0);

        // Single fetch, minimum latency
        if_req = 1; if_addr = 32'h100; mem_gnt = 1;
        step();
        check("sf_gnt_c0", o_if_gnt, 1);
        if_req = 0;
        step();
        check("sf_mem_req_c1", o_mem_req, 1);
        check("sf_mem_addr_c1", o_mem_addr, 32'h100);
        check("sf_sel_c1", o_sel, 0);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        check("sf_busy_c2", o_busy, 1);
        mem_rvalid = 0;
        step();
        check("sf_rvalid_c3", o_if_rvalid, 1);
        check("sf_rdata_c3", o_if_rdata, 32'hDEAD_BEEF);
        check("sf_sel_c3", o_sel, 0);

        // Contention: data write wins, fetch follows in the rvalid cycle
        if_req = 1; if_addr = 32'h180;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_be = 4'hF;
        mem_gnt = 1;
        step();
        check("ct_d_gnt", o_d_gnt, 1);
        check("ct_if_gnt", o_if_gnt, 0);
        d_req = 0;
        step();
        check("ct_mem_we", o_mem_we, 1);
        check("ct_sel", o_sel, 1);
        check("ct_mem_wdata", o_mem_wdata, 32'h1234_5678);
        mem_rvalid = 1; mem_rdata = 32'h0;
        step();
        mem_rvalid = 0;
        step();
        check("ct_d_rvalid", o_d_rvalid, 1);
        check("ct_if_gnt_after", o_if_gnt, 1);
        drain(4);

        // Memory stall
        d_req = 1; d_we = 0; d_addr = 32'h300; mem_gnt = 0; mem_rvalid = 0;
        step();
        check("st_d_gnt", o_d_gnt, 1);
        d_req = 0; if_addr = 32'h340;
        n_req = 0; n_gnt = 0; n_rv = 0;
        for (int c = 1; c <= 11; c++) begin
            mem_gnt = (c == 6); mem_rvalid = (c == 10); if_req = (c <= 10);
            mem_rdata = 32'hCAFE_0000 + 32'(c);
            step();
            n_req += int'(o_mem_req);
            if (c <= 10) n_gnt += int'(o_if_gnt) + int'(o_d_gnt);
            n_rv += int'(o_if_rvalid) + int'(o_d_rvalid);
        end
        check("st_mem_req_cycles", n_req, 6);
        check("st_gnt_while_busy", n_gnt, 0);
        check("st_rvalid_count", n_rv, 1);
        check("st_d_rdata", o_d_rdata, 32'hCAFE_000A);

        // Reset while in WAIT
        if_req = 1; if_addr = 32'h400; mem_gnt = 1; mem_rvalid = 0;
        step();
        if_req = 0;
        step();
        mem_gnt = 0; rst_n = 0;
        step();
        rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h0BAD_0BAD;
        step();
        check("rw_busy", o_busy, 0);
        n_rv = int'(o_if_rvalid) + int'(o_d_rvalid);
        mem_rvalid = 0;
        step();
        n_rv += int'(o_if_rvalid) + int'(o_d_rvalid);
        check("rw_no_rvalid", n_rv, 0);
        d_req = 1; d_we = 0; d_addr = 32'h500;
        step();
        check("rw_next_gnt", o_d_gnt, 1);
        drain(4);

        // Starvation behaviour with both sides requesting continuously
        rst_n = 0; quiet_inputs();
        step();
        rst_n = 1;
        if_req = 1; d_req = 1; d_we = 0; mem_gnt = 1; mem_rvalid = 1;
        n_grants = 0;
        for (int c = 0; c < 200 && n_grants < 15; c++) begin
            if_addr = $urandom; d_addr = $urandom; mem_rdata = $urandom;
            step();
            if (o_if_gnt || o_d_gnt) begin
                order[n_grants] = o_if_gnt;
                n_grants++;
            end
        end
        check("sv_grant_count", n_grants, 15);
        for (int k = 0; k < n_grants; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            check("sv_order", order[k], (k % 5) == 4);
`else
            check("sv_order", order[k], 0);
`endif
        end
        drain(4);

        // Random traffic against the model
        if_pend = 0; d_pend = 0;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (!rst_n) begin
                if_pend = 0; d_pend = 0;
            end else begin
                if (!if_pend && $urandom_range(0, 2) == 0) begin
                    if_pend = 1; if_addr = $urandom;
                end
                if (!d_pend && $urandom_range(0, 2) == 0) begin
                    d_pend = 1; d_we = $urandom_range(0, 1); d_addr = $urandom;
                    d_wdata = $urandom; d_be = BW'($urandom);
                end
            end
            if_req = if_pend; d_req = d_pend;
            mem_gnt = ($urandom_range(0, 2) == 0);
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            step();
            if (e_if_gnt) if_pend = 0;
            if (e_d_gnt) d_pend = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
